// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [15:0] DEF_RESET_PC = 16'h0001;
  localparam logic [15:0] DEF_LAST_PC  = 16'h0003;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM / decode-side bundle of the fetch sequencer; master is the fetch controller.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_valid;
  logic               halted;

  modport master (
    output rom_addr, if_instr, if_pc, if_valid, halted,
    input  rom_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  rom_addr, if_instr, if_pc, if_valid, halted,
    output rom_data, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch sequencer.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= sat_inc(fetch_cnt, fetch_inc);
      stall_cnt <= sat_inc(stall_cnt, stall_inc);
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: PC/FSM, ROM addressing and IF/ID register with valid flag.
// Optional perf counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEF_LAST_PC)
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] if_instr_p1, if_instr_nxt;
  logic [ADDR_W-1:0]  if_pc_p1, if_pc_nxt;
  logic               vld_p1, vld_nxt;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_instr_nxt = if_instr_p1;
    if_pc_nxt    = if_pc_p1;
    vld_nxt      = vld_p1;
    case (state)
      IDLE: begin
        state_nxt = RUN;
        vld_nxt   = 1'b0;
      end
      RUN: begin
        if (bus.redirect) begin
          pc_nxt       = bus.redirect_pc;
          vld_nxt      = 1'b0;
          if_instr_nxt = INSTR_W'(NOP_INSTR);
        end else if (!bus.stall) begin
          if_instr_nxt = bus.rom_data;
          if_pc_nxt    = pc;
          vld_nxt      = 1'b1;
          // PC saturates at all-ones; anything at or past LAST_PC ends the program
          if (pc != '1) pc_nxt = pc + ADDR_W'(1);
          if (pc >= LAST_PC) state_nxt = HALT;
        end
      end
      HALT: begin
        if (bus.redirect) begin
          pc_nxt       = bus.redirect_pc;
          vld_nxt      = 1'b0;
          if_instr_nxt = INSTR_W'(NOP_INSTR);
          state_nxt    = RUN;
        end else if (!bus.stall) begin
          vld_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- IF/ID stage boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_instr_p1 <= '0;
      if_pc_p1    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_instr_p1 <= if_instr_nxt;
      if_pc_p1    <= if_pc_nxt;
      vld_p1      <= vld_nxt;
    end
  end

  assign bus.rom_addr = pc;
  assign bus.if_instr = if_instr_p1;
  assign bus.if_pc    = if_pc_p1;
  assign bus.if_valid = vld_p1;
  assign bus.halted   = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  assign fetch_inc = (state == RUN) && !bus.redirect && !bus.stall;
  assign stall_inc = (state == RUN) && !bus.redirect &&  bus.stall;

  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (fetch_inc),
    .stall_inc (stall_inc),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule
